// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency meter in the ClkIn domain
// Optional macro PERIOD_MEAS_EN adds a Period output (ClkIn cycles between edges).
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32
) (
    input  logic             ClkIn,
    input  logic             rst,
    input  logic             En,
    input  logic             SigIn,
    output logic [CNT_W-1:0] Freq,
    output logic             Done,
    output logic             Ovf,
    output logic             Busy
`ifdef PERIOD_MEAS_EN
    ,
    output logic [CNT_W-1:0] Period
`endif
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t state, state_nxt;

    logic             sync1, sync2, hist;
    logic             sig_edge;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_acc;
    logic             win_end;
    logic             edge_at_max;
    logic [CNT_W-1:0] edge_sum;

    always_ff @(posedge ClkIn or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= SigIn;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign sig_edge    = sync2 & ~hist;
    assign edge_at_max = sig_edge && (edge_cnt == CNT_MAX);
    // Saturating add: an edge at the limit leaves the count pinned.
    assign edge_sum    = edge_at_max ? edge_cnt : edge_cnt + CNT_W'(sig_edge);

    always_ff @(posedge ClkIn or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_end   = 1'b0;
        case (state)
            IDLE: begin
                if (En) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (gate_cnt == GATE_LAST) begin
                    win_end = 1'b1;
                    if (!En) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state == COUNT);

    always_ff @(posedge ClkIn or negedge rst) begin
        if (!rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            Freq     <= '0;
            Ovf      <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == COUNT) begin
                if (win_end) begin
                    // The edge seen in the last gate cycle still belongs to this window.
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_acc  <= 1'b0;
                    Freq     <= edge_sum;
                    Ovf      <= ovf_acc | edge_at_max;
                    Done     <= 1'b1;
                end else begin
                    gate_cnt <= gate_cnt + GW'(1);
                    edge_cnt <= edge_sum;
                    if (edge_at_max) begin
                        ovf_acc <= 1'b1;
                    end
                end
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_acc  <= 1'b0;
            end
        end
    end

`ifdef PERIOD_MEAS_EN
    logic [CNT_W-1:0] per_cnt;
    logic             per_seen;

    always_ff @(posedge ClkIn or negedge rst) begin
        if (!rst) begin
            per_cnt  <= '0;
            per_seen <= 1'b0;
            Period   <= '0;
        end else if (state == COUNT) begin
            if (sig_edge) begin
                // The first edge after IDLE only starts the interval.
                per_cnt  <= '0;
                per_seen <= 1'b1;
                if (per_seen) begin
                    Period <= (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);
                end
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
        end else begin
            per_cnt  <= '0;
            per_seen <= 1'b0;
        end
    end
`endif

endmodule
